// File: rtl/gate_sweep_checker.sv
// Stimulus/checker for a two-input gate: walks {I1,I2} through 00..11 for PASSES
// sweeps, samples O after SETTLE cycles per vector and scores it against TRUTH.
module gate_sweep_checker #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned PASSES = 1,
  parameter logic [3:0]  TRUTH  = 4'b0001
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  output logic       I1,
  output logic       I2,
  input  logic       O,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [7:0] ERR_CNT,
  output logic [1:0] FIRST_FAIL
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);
  localparam logic [3:0] PASS_LAST = 4'(PASSES - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    if (v == 8'd255) begin
      return 8'd255;
    end else begin
      return v + 8'd1;
    end
  endfunction

  state_t     state_r;
  logic [1:0] idx_r;
  logic [3:0] pass_cnt_r;
  logic [3:0] settle_r;
  logic [7:0] err_cnt_r;
  logic [1:0] first_fail_r;
  logic       i1_r;
  logic       i2_r;
  logic       busy_r;
  logic       done_r;
  logic       pass_r;

  logic       miss_s;
  logic       last_s;
  logic [1:0] idx_nxt_s;

  // Sample-edge decode: truth-table mismatch and last-vector-of-run detection
  always_comb begin
    miss_s    = 1'b0;
    last_s    = 1'b0;
    idx_nxt_s = 2'd0;
    miss_s    = (O != TRUTH[idx_r]);
    last_s    = (idx_r == 2'd3) && (pass_cnt_r == PASS_LAST);
    idx_nxt_s = idx_r + 2'd1;
  end

  // Sweep controller; every output is a register updated here
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      idx_r        <= 2'd0;
      pass_cnt_r   <= 4'd0;
      settle_r     <= 4'd0;
      err_cnt_r    <= 8'd0;
      first_fail_r <= 2'd0;
      i1_r         <= 1'b0;
      i2_r         <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_FIN: begin
          if (START) begin
            state_r      <= ST_RUN;
            idx_r        <= 2'd0;
            pass_cnt_r   <= 4'd0;
            settle_r     <= SETTLE_LD;
            err_cnt_r    <= 8'd0;
            first_fail_r <= 2'd0;
            i1_r         <= 1'b0;
            i2_r         <= 1'b0;
            busy_r       <= 1'b1;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        ST_RUN: begin
          if (settle_r != 4'd0) begin
            settle_r <= settle_r - 4'd1;
          end else begin
            // FIRST_FAIL latches only on the transition of the count away from zero
            if (miss_s) begin
              err_cnt_r <= sat_inc(err_cnt_r);
              if (err_cnt_r == 8'd0) begin
                first_fail_r <= idx_r;
              end else begin
                first_fail_r <= first_fail_r;
              end
            end else begin
              err_cnt_r <= err_cnt_r;
            end
            if (last_s) begin
              state_r    <= ST_FIN;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
              pass_r     <= (err_cnt_r == 8'd0) && !miss_s;
              i1_r       <= 1'b0;
              i2_r       <= 1'b0;
              idx_r      <= 2'd0;
              pass_cnt_r <= 4'd0;
            end else begin
              idx_r    <= idx_nxt_s;
              i1_r     <= idx_nxt_s[1];
              i2_r     <= idx_nxt_s[0];
              settle_r <= SETTLE_LD;
              if (idx_r == 2'd3) begin
                pass_cnt_r <= pass_cnt_r + 4'd1;
              end else begin
                pass_cnt_r <= pass_cnt_r;
              end
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          i1_r    <= 1'b0;
          i2_r    <= 1'b0;
        end
      endcase
    end
  end

  assign I1         = i1_r;
  assign I2         = i2_r;
  assign BUSY       = busy_r;
  assign DONE       = done_r;
  assign PASS       = pass_r;
  assign ERR_CNT    = err_cnt_r;
  assign FIRST_FAIL = first_fail_r;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench: three checker instances with different SETTLE/PASSES drive a
// behavioural gate; each run's expected trace and verdict is queued at START.
module tb_gate_sweep_checker;

  localparam int N = 3;
  localparam int SET_P [N] = '{2, 1, 1};
  localparam int PAS_P [N] = '{1, 3, 15};
  localparam logic [3:0] TRUTH_P = 4'b0001;
  localparam logic [3:0] G_NOR = 4'b0001;

  typedef struct {
    logic [7:0]   err;
    logic [1:0]   ff;
    logic         pass;
    int           len;
    logic [255:0] seq;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s   [N];
  logic       start_s [N];
  logic       o_s     [N];
  logic       i1_s    [N];
  logic       i2_s    [N];
  logic       busy_s  [N];
  logic       done_s  [N];
  logic       pass_s  [N];
  logic [7:0] err_s   [N];
  logic [1:0] ff_s    [N];
  logic [3:0] gate_tt [N];

  exp_t exp_q [N][$];
  int   n_vec = 0;
  int   n_bad = 0;

  for (genvar g = 0; g < N; g++) begin : gen_dut
    assign o_s[g] = gate_tt[g][{i1_s[g], i2_s[g]}];
    gate_sweep_checker #(.SETTLE(SET_P[g]), .PASSES(PAS_P[g]), .TRUTH(TRUTH_P)) u_dut (
      .CLK(clk), .RST(rst_s[g]), .START(start_s[g]), .I1(i1_s[g]), .I2(i2_s[g]),
      .O(o_s[g]), .BUSY(busy_s[g]), .DONE(done_s[g]), .PASS(pass_s[g]),
      .ERR_CNT(err_s[g]), .FIRST_FAIL(ff_s[g])
    );
  end

  task automatic check(input string name, input int k, input logic [255:0] act,
                       input logic [255:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %0h required %0h", name, k, act, req);
    end
  endtask

  // Reference: what one full run must produce, straight from the sweep rules
  function automatic exp_t ref_run(input int k, input logic [3:0] tt);
    exp_t e;
    int errs  = 0;
    int first = -1;
    int pos   = 0;
    e.seq = '0;
    for (int p = 0; p < PAS_P[k]; p++) begin
      for (int v = 0; v < 4; v++) begin
        if (tt[v] != TRUTH_P[v]) begin
          errs++;
          if (first < 0) first = v;
        end
        for (int s = 0; s < SET_P[k]; s++) begin
          e.seq[pos*2 +: 2] = 2'(v);
          pos++;
        end
      end
    end
    e.err  = (errs > 255) ? 8'd255 : 8'(errs);
    e.ff   = (first < 0) ? 2'd0 : 2'(first);
    e.pass = (errs == 0);
    e.len  = pos;
    return e;
  endfunction

  // Monitor: record {I1,I2} while BUSY, score the run when DONE rises
  logic [255:0] tr_seq [N] = '{default: '0};
  int           tr_len [N] = '{default: 0};
  logic         done_q [N] = '{default: 1'b0};
  exp_t         mon_e;

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (rst_s[k]) begin
          tr_len[k] = 0;
          tr_seq[k] = '0;
        end else if (busy_s[k]) begin
          if (tr_len[k] < 128) tr_seq[k][tr_len[k]*2 +: 2] = {i1_s[k], i2_s[k]};
          tr_len[k]++;
        end
        if (done_s[k] && !done_q[k]) begin
          if (exp_q[k].size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_done inst%0d: got DONE with no run queued", k);
          end else begin
            mon_e = exp_q[k].pop_front();
            check("err_cnt", k, err_s[k], mon_e.err);
            check("first_fail", k, ff_s[k], mon_e.ff);
            check("pass", k, pass_s[k], mon_e.pass);
            check("busy_len", k, tr_len[k], mon_e.len);
            check("vector_seq", k, tr_seq[k], mon_e.seq);
            check("idle_outs", k, {busy_s[k], i1_s[k], i2_s[k]}, 3'b000);
          end
          tr_len[k] = 0;
          tr_seq[k] = '0;
        end
        done_q[k] = done_s[k];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int k);
    start_s[k] = 1'b1;
    tick();
    start_s[k] = 1'b0;
  endtask

  task automatic run(input int k, input logic [3:0] tt);
    gate_tt[k] = tt;
    exp_q[k].push_back(ref_run(k, tt));
    pulse_start(k);
  endtask

  task automatic wait_done(input int k);
    int c = 0;
    while (!(done_s[k] === 1'b1 && busy_s[k] === 1'b0) && c < 200) begin
      tick();
      c++;
    end
    if (c >= 200) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout inst%0d: got no DONE in %0d cycles, required DONE", k, c);
    end
    tick();
  endtask

  task automatic check_all_zero(input string name, input int k);
    check(name, k, {i1_s[k], i2_s[k], busy_s[k], done_s[k], pass_s[k], err_s[k], ff_s[k]},
          '0);
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      rst_s[k]   = 1'b1;
      start_s[k] = 1'b0;
      gate_tt[k] = G_NOR;
    end
    repeat (3) tick();
    for (int k = 0; k < N; k++) rst_s[k] = 1'b0;
    tick();
    for (int k = 0; k < N; k++) check_all_zero("reset_state", k);

    run(0, G_NOR);   wait_done(0);   // correct NOR gate
    run(0, 4'b0000); wait_done(0);   // O stuck at 0
    run(1, 4'b1000); wait_done(1);   // AND gate, 3 passes
    run(2, 4'b1111); wait_done(2);   // O stuck at 1, 15 passes

    // Reset mid-run aborts cleanly, then a fresh run completes
    gate_tt[0] = G_NOR;
    pulse_start(0);
    repeat (4) tick();
    rst_s[0] = 1'b1;
    tick();
    rst_s[0] = 1'b0;
    check_all_zero("mid_run_reset", 0);
    run(0, G_NOR); wait_done(0);

    // START during RUN is ignored; START after DONE restarts
    run(0, G_NOR);
    tick();
    tick();
    pulse_start(0);
    wait_done(0);
    repeat (2) tick();
    run(0, G_NOR);
    check("restart_clears", 0, {busy_s[0], done_s[0], pass_s[0]}, 3'b100);
    wait_done(0);

    // Saturation: preload the count near the top, remaining mismatches clamp it
    run(2, 4'b1111);
    exp_q[2][exp_q[2].size()-1].err = 8'd255;
    tick();
    tick();
    force gen_dut[2].u_dut.err_cnt_r = 8'd254;
    #1;
    release gen_dut[2].u_dut.err_cnt_r;
    wait_done(2);

    // Random gates on random instances
    for (int it = 0; it < 8; it++) begin
      int k;
      k = int'($urandom_range(0, N - 1));
      repeat ($urandom_range(0, 3)) tick();
      run(k, 4'($urandom));
      wait_done(k);
    end

    for (int k = 0; k < N; k++) check("queue_drained", k, exp_q[k].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
